// File: rtl/ckegen_pkg.sv
// Shared types for the clock-enable generator bank: channel mode and sequencer state.
package ckegen_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_CONT    = 2'd1,
        MODE_ONESHOT = 2'd2
    } ckemode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2
    } ckestate_t;

endpackage

// File: rtl/ckegen_ch.sv
// One clock-enable channel: shadow/live configuration, IDLE/DELAY/RUN sequencer,
// and pulse/level/active decode from the registered state.
module ckegen_ch
    import ckegen_pkg::*;
#(
    parameter int W          = 26,
    parameter int DEF_PERIOD = 50000000,
    parameter int AUTO_START = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_high,
    input  logic [W-1:0] cfg_phase,
    input  ckemode_t     cfg_mode,
    input  logic         sync,
    output logic         pulse,
    output logic         level,
    output logic         active
);
    localparam logic [W-1:0] RST_PERIOD = W'(DEF_PERIOD);
    localparam logic [W-1:0] RST_HIGH   = W'(DEF_PERIOD >> 1);
    localparam ckemode_t     RST_MODE   = (AUTO_START != 0) ? MODE_CONT : MODE_OFF;
    localparam ckestate_t    RST_STATE  = (AUTO_START != 0) ? ST_RUN : ST_IDLE;

    ckestate_t    state_r, state_s;
    logic [W-1:0] cnt_r, cnt_s, dcnt_r, dcnt_s;
    logic [W-1:0] sh_period_r, sh_high_r, sh_phase_r;
    ckemode_t     sh_mode_r;
    logic [W-1:0] lv_period_r, lv_high_r, lv_phase_r;
    logic [W-1:0] lv_period_s, lv_high_s, lv_phase_s;
    ckemode_t     lv_mode_r, lv_mode_s;
    logic [W-1:0] ef_period_s, ef_high_s, ef_phase_s;
    ckemode_t     ef_mode_s;
    logic [W-1:0] last_s;
    logic         restart_s;

    // Shadow as seen this cycle (a concurrent write lands first) and the wrap count; period 0 acts as 1
    always_comb begin
        if (we) begin
            ef_period_s = cfg_period;
            ef_high_s   = cfg_high;
            ef_phase_s  = cfg_phase;
            ef_mode_s   = cfg_mode;
        end else begin
            ef_period_s = sh_period_r;
            ef_high_s   = sh_high_r;
            ef_phase_s  = sh_phase_r;
            ef_mode_s   = sh_mode_r;
        end
        if (lv_period_r == W'(0)) begin
            last_s = W'(0);
        end else begin
            last_s = lv_period_r - W'(1);
        end
    end

    // Next-state logic: restart (sync or start from IDLE), phase delay, period counting and wrap
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        dcnt_s      = dcnt_r;
        lv_period_s = lv_period_r;
        lv_high_s   = lv_high_r;
        lv_phase_s  = lv_phase_r;
        lv_mode_s   = lv_mode_r;
        restart_s   = (sync && (ef_mode_s != MODE_OFF)) ||
                      ((state_r == ST_IDLE) && we && (cfg_mode != MODE_OFF));
        if (restart_s) begin
            lv_period_s = ef_period_s;
            lv_high_s   = ef_high_s;
            lv_phase_s  = ef_phase_s;
            lv_mode_s   = ef_mode_s;
            cnt_s       = W'(0);
            dcnt_s      = W'(0);
            if (ef_phase_s != W'(0)) begin
                state_s = ST_DELAY;
            end else begin
                state_s = ST_RUN;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (we) begin
                        lv_period_s = ef_period_s;
                        lv_high_s   = ef_high_s;
                        lv_phase_s  = ef_phase_s;
                        lv_mode_s   = ef_mode_s;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    if (dcnt_r == lv_phase_r - W'(1)) begin
                        state_s = ST_RUN;
                        cnt_s   = W'(0);
                        dcnt_s  = W'(0);
                    end else begin
                        dcnt_s = dcnt_r + W'(1);
                    end
                end
                ST_RUN: begin
                    if (cnt_r == last_s) begin
                        lv_period_s = ef_period_s;
                        lv_high_s   = ef_high_s;
                        lv_phase_s  = ef_phase_s;
                        lv_mode_s   = ef_mode_s;
                        cnt_s       = W'(0);
                        if ((ef_mode_s == MODE_OFF) || (lv_mode_r == MODE_ONESHOT)) begin
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        cnt_s = cnt_r + W'(1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = W'(0);
                    dcnt_s  = W'(0);
                end
            endcase
        end
    end

    // State, counter and configuration registers; reset drops any pending shadow write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= RST_STATE;
            cnt_r       <= W'(0);
            dcnt_r      <= W'(0);
            sh_period_r <= RST_PERIOD;
            sh_high_r   <= RST_HIGH;
            sh_phase_r  <= W'(0);
            sh_mode_r   <= RST_MODE;
            lv_period_r <= RST_PERIOD;
            lv_high_r   <= RST_HIGH;
            lv_phase_r  <= W'(0);
            lv_mode_r   <= RST_MODE;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            dcnt_r      <= dcnt_s;
            sh_period_r <= ef_period_s;
            sh_high_r   <= ef_high_s;
            sh_phase_r  <= ef_phase_s;
            sh_mode_r   <= ef_mode_s;
            lv_period_r <= lv_period_s;
            lv_high_r   <= lv_high_s;
            lv_phase_r  <= lv_phase_s;
            lv_mode_r   <= lv_mode_s;
        end
    end

    assign pulse  = ~rst & (state_r == ST_RUN) & (cnt_r == W'(0));
    assign level  = ~rst & (state_r == ST_RUN) & (cnt_r < lv_high_r);
    assign active = ~rst & (state_r != ST_IDLE);

endmodule

// File: rtl/ckegen_bank.sv
// Bank of N_CH independent clock-enable channels: configuration write demux and sync fan-out.
module ckegen_bank
    import ckegen_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int W          = 26,
    parameter int DEF_PERIOD = 50000000,
    parameter int AUTO_START = 1,
    localparam int CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [CW-1:0]   cfg_ch,
    input  logic [W-1:0]    cfg_period,
    input  logic [W-1:0]    cfg_high,
    input  logic [W-1:0]    cfg_phase,
    input  ckemode_t        cfg_mode,
    input  logic            sync,
    output logic [N_CH-1:0] pulse,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] active
);
    logic [N_CH-1:0] we_s;

    if (W < $clog2(DEF_PERIOD)) begin : g_width_check
        $error("ckegen_bank: W is too narrow to hold DEF_PERIOD");
    end

    // Channel indices at or beyond N_CH match no instance, so such writes fall away
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign we_s[i] = cfg_we && (cfg_ch == CW'(i));

        ckegen_ch #(
            .W          (W),
            .DEF_PERIOD (DEF_PERIOD),
            .AUTO_START (AUTO_START)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .we         (we_s[i]),
            .cfg_period (cfg_period),
            .cfg_high   (cfg_high),
            .cfg_phase  (cfg_phase),
            .cfg_mode   (cfg_mode),
            .sync       (sync),
            .pulse      (pulse[i]),
            .level      (level[i]),
            .active     (active[i])
        );
    end

endmodule

// File: tb/tb_ckegen_bank.sv
// Scoreboarded bench for ckegen_bank: directed scenarios plus random traffic against a
// position-based reference model of each channel.
module tb_ckegen_bank;
    import ckegen_pkg::*;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int DP = 10;

    logic         clk        = 1'b0;
    logic         rst        = 1'b1;
    logic         cfg_we     = 1'b0;
    logic [1:0]   cfg_ch     = 2'd0;
    logic [W-1:0] cfg_period = 8'd0;
    logic [W-1:0] cfg_high   = 8'd0;
    logic [W-1:0] cfg_phase  = 8'd0;
    ckemode_t     cfg_mode   = MODE_OFF;
    logic         sync       = 1'b0;
    logic [N-1:0] pulse, level, active;

    ckegen_bank #(
        .N_CH(N), .W(W), .DEF_PERIOD(DP), .AUTO_START(1)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
        .cfg_mode(cfg_mode), .sync(sync),
        .pulse(pulse), .level(level), .active(active)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit done       = 1'b0;
    logic [3*N-1:0] expq[$];
    logic [3*N-1:0] mon_exp, mon_got;

    // Reference model: config sets, a busy flag, a start delay and a position counter
    // measured from the start of the current segment (delay followed by one period).
    int sh_per[N], sh_hi[N], sh_ph[N], sh_md[N];
    int lv_per[N], lv_hi[N], lv_ph[N], lv_md[N];
    bit busy[N];
    int dly[N], pos[N];

    function void m_reset();
        for (int i = 0; i < N; i++) begin
            sh_per[i] = DP; sh_hi[i] = DP / 2; sh_ph[i] = 0; sh_md[i] = 1;
            lv_per[i] = DP; lv_hi[i] = DP / 2; lv_ph[i] = 0; lv_md[i] = 1;
            busy[i] = 1'b1; dly[i] = 0; pos[i] = 0;
        end
    endfunction

    function logic [3*N-1:0] m_out();
        logic [N-1:0] p, l, a;
        p = '0; l = '0; a = '0;
        for (int i = 0; i < N; i++) begin
            if (busy[i]) begin
                a[i] = 1'b1;
                if (pos[i] >= dly[i]) begin
                    p[i] = ((pos[i] - dly[i]) == 0);
                    l[i] = ((pos[i] - dly[i]) < lv_hi[i]);
                end
            end
        end
        return {p, l, a};
    endfunction

    function void m_step(bit w, int ch, int per, int hi, int ph, int md, bit s);
        for (int i = 0; i < N; i++) begin
            bit wi;
            int ep, old;
            wi = w && (ch == i);
            if (wi) begin
                sh_per[i] = per; sh_hi[i] = hi; sh_ph[i] = ph; sh_md[i] = md;
            end
            if (s && sh_md[i] != 0) begin
                lv_per[i] = sh_per[i]; lv_hi[i] = sh_hi[i]; lv_ph[i] = sh_ph[i]; lv_md[i] = sh_md[i];
                busy[i] = 1'b1; dly[i] = lv_ph[i]; pos[i] = 0;
            end else if (!busy[i]) begin
                if (wi) begin
                    lv_per[i] = per; lv_hi[i] = hi; lv_ph[i] = ph; lv_md[i] = md;
                    if (md != 0) begin
                        busy[i] = 1'b1; dly[i] = ph; pos[i] = 0;
                    end
                end
            end else begin
                ep = (lv_per[i] == 0) ? 1 : lv_per[i];
                if (pos[i] >= dly[i] && (pos[i] - dly[i]) == ep - 1) begin
                    old = lv_md[i];
                    lv_per[i] = sh_per[i]; lv_hi[i] = sh_hi[i]; lv_ph[i] = sh_ph[i]; lv_md[i] = sh_md[i];
                    if (sh_md[i] == 0 || old == 2) busy[i] = 1'b0;
                    else begin
                        dly[i] = 0; pos[i] = 0;
                    end
                end else begin
                    pos[i] = pos[i] + 1;
                end
            end
        end
    endfunction

    task automatic step(bit r, bit w, int ch, int per, int hi, int ph, int md, bit s);
        @(posedge clk);
        #1;
        rst        = r;
        cfg_we     = w;
        cfg_ch     = 2'(ch);
        cfg_period = W'(per);
        cfg_high   = W'(hi);
        cfg_phase  = W'(ph);
        cfg_mode   = ckemode_t'(2'(md));
        sync       = s;
        cyc++;
        if (r) begin
            m_reset();
            expq.push_back('0);
        end else begin
            expq.push_back(m_out());
            m_step(w, ch, per, hi, ph, md, s);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic check_reset_state();
        #1;
        compared++;
        if ({pulse, level, active} !== {(3*N){1'b0}}) begin
            mismatched++;
            $display("FAIL reset state cyc %0d: pulse=%b level=%b active=%b while rst high",
                     cyc, pulse, level, active);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_exp = expq.pop_front();
            mon_got = {pulse, level, active};
            compared++;
            if (mon_got !== mon_exp) begin
                mismatched++;
                $display("FAIL outputs cyc %0d: got pulse=%b level=%b active=%b, expected pulse=%b level=%b active=%b",
                         cyc, mon_got[3*N-1:2*N], mon_got[2*N-1:N], mon_got[N-1:0],
                         mon_exp[3*N-1:2*N], mon_exp[2*N-1:N], mon_exp[N-1:0]);
            end
        end
    end

    // Watchdog: the stimulus must complete within a bounded number of cycles
    initial begin
        #200000;
        if (!done) begin
            mismatched++;
            $display("FAIL timeout: stimulus did not complete, cyc %0d", cyc);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $finish;
        end
    end

    initial begin
        m_reset();
        repeat (3) step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        check_reset_state();
        idle(25);
        // ch1 to OFF (idles at its wrap), then a delayed CONT start
        step(1'b0, 1'b1, 1, 10, 5, 0, 0, 1'b0);
        idle(12);
        step(1'b0, 1'b1, 1, 4, 1, 3, 1, 1'b0);
        idle(14);
        // pending period change on a running channel
        step(1'b0, 1'b1, 0, 3, 1, 0, 1, 1'b0);
        idle(20);
        // one-shot, then sync re-arms it
        step(1'b0, 1'b1, 2, 5, 2, 0, 2, 1'b0);
        idle(25);
        step(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b1);
        idle(10);
        // write coinciding with sync, then period 0
        step(1'b0, 1'b1, 0, 2, 1, 0, 1, 1'b1);
        idle(8);
        step(1'b0, 1'b1, 1, 0, 1, 0, 1, 1'b0);
        idle(12);
        // out-of-range channel write must be ignored
        step(1'b0, 1'b1, 3, 5, 1, 0, 1, 1'b1);
        idle(6);
        // reset mid-period with a pending shadow write
        step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        idle(7);
        step(1'b0, 1'b1, 0, 7, 2, 1, 1, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        check_reset_state();
        step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        check_reset_state();
        idle(25);
        for (int k = 0; k < 3000; k++) begin
            int m;
            m = $urandom_range(0, 5);
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3),
                 $urandom_range(0, 9),
                 $urandom_range(0, 10),
                 $urandom_range(0, 4),
                 (m == 0) ? 0 : ((m <= 3) ? 1 : 2),
                 $urandom_range(0, 29) == 0);
        end
        idle(2);
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ckegen_bank.md
CKEGEN_BANK -- requirements
Module: ckegen_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent clock-enable channels, 1..16.
REQ-002 SHALL have parameter W, default 26: counter/config width; the module SHALL check at elaboration that W >= $clog2(DEF_PERIOD).
REQ-003 SHALL have parameter DEF_PERIOD, default 50000000: reset period of every channel.
REQ-004 SHALL have parameter AUTO_START, default 1: 1 = channels run in CONT mode out of reset; 0 = channels sit in OFF mode.
REQ-005 clk  in  1  single clock, all state on posedge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 cfg_we  in  1  configuration write strobe.
REQ-008 cfg_ch  in  max(1,$clog2(N_CH))  target channel; writes with cfg_ch >= N_CH SHALL be ignored.
REQ-009 cfg_period, cfg_high, cfg_phase  in  W each  period, high-time and start delay, in cycles.
REQ-010 cfg_mode  in  2  ckemode_t: OFF, CONT, ONESHOT.
REQ-011 sync  in  1  global restart strobe.
REQ-012 pulse  out  N_CH  one-cycle enable at the start of each period (ckegen1 successor).
REQ-013 level  out  N_CH  duty-cycle enable (ckegen2 successor).
REQ-014 active  out  N_CH  channel is not IDLE.

Function
REQ-015 Each channel SHALL hold shadow registers (period, high, phase, mode) and live registers; states SHALL be IDLE, DELAY, RUN.
REQ-016 A cfg_we SHALL write the shadow registers of cfg_ch; it SHALL be copied to live immediately if that channel is IDLE, otherwise at the channel's next wrap.
REQ-017 IDLE SHALL transition, on the cycle after live mode becomes non-OFF, to DELAY with dcnt=0 if phase>0, else to RUN with cnt=0.
REQ-018 DELAY: dcnt SHALL increment each cycle; at dcnt==phase-1 the next state SHALL be RUN with cnt=0.
REQ-019 RUN: cnt SHALL increment each cycle and wrap to 0 after cnt==period-1, which is the wrap cycle.
REQ-020 At wrap, shadow SHALL be copied to live; new mode OFF or old mode ONESHOT SHALL go to IDLE; otherwise the channel SHALL stay in RUN.
REQ-021 A period of 0 SHALL be treated as 1; with period 1, pulse SHALL be high on every RUN cycle.
REQ-022 pulse SHALL equal RUN && cnt==0; level SHALL equal RUN && cnt<high, so high=0 gives level never high and high>=period gives level always high in RUN.
REQ-023 All outputs SHALL be decoded combinationally from registered state and SHALL be forced to 0 while rst is high.
REQ-024 sync SHALL restart every channel whose shadow mode is non-OFF as in REQ-017, including ONESHOT channels that are already IDLE, copying shadow to live.
REQ-025 If cfg_we and sync coincide, the write SHALL be applied first and the restart SHALL use the new configuration.
REQ-026 Counters SHALL compare unsigned W-bit values with no overflow beyond period-1.

Reset
REQ-027 rst SHALL immediately set all cnt and dcnt to 0, shadow and live period to DEF_PERIOD, high to DEF_PERIOD>>1, and phase to 0.
REQ-028 With AUTO_START=1, reset SHALL set mode to CONT and state to RUN, so pulse is high in the first cycle after release (ckegen1-compatible); with AUTO_START=0, reset SHALL set mode to OFF and state to IDLE.
REQ-029 Reset asserted mid-period SHALL abandon all pending shadow updates.

Structure
REQ-030 Package ckegen_pkg SHALL hold the ckemode_t and ckestate_t enums.
REQ-031 Per-channel logic SHALL be sub-module ckegen_ch, instantiated N_CH times by a generate loop; ckegen_bank SHALL contain only config demux and sync fan-out.

Verification
REQ-032 AUTO_START=1, DEF_PERIOD=10, N_CH=2, release rst -> pulse[0] high in cycles 0, 10, 20; level[0] high in cycles 0-4 of each period.
REQ-033 Ch1 IDLE, write period=4, high=1, phase=3, mode=CONT -> active next cycle; first pulse 1+3 cycles after the write; then every 4 cycles, level high in pulse cycles only.
REQ-034 While running period=10, write period=3 at cnt=5 -> period stays 10 until wrap, then pulses every 3 cycles.
REQ-035 ONESHOT with period=5 -> exactly one pulse, active drops after 5 RUN cycles; sync -> exactly one more pulse.
REQ-036 cfg_we (period=2) and sync in the same cycle -> all non-OFF channels pulse the next cycle and then every 2 cycles; period=0 write -> pulse every RUN cycle.
REQ-037 Assert rst at cnt=7 with a shadow write pending -> all outputs 0 immediately; after release DEF_PERIOD behaviour with no trace of the pending write.
